// File: rtl/imc_obuf_pkg.sv
// Shared definitions for the IMC output-buffer read path: FSM states and pipeline geometry.
package imc_obuf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } obuf_state_e;

  localparam int OBUF_SKID_DEPTH = 2;
  localparam int OBUF_RD_LATENCY = 1;

endpackage

// File: rtl/imc_obuf_reader_if.sv
// Control, buffer read port and output stream of the output-buffer reader, seen from the reader (master).
interface imc_obuf_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   num_words;
  logic                  busy;
  logic                  done;
  logic                  buf_empty;
  logic [DATA_WIDTH-1:0] buf_rd_data;
  logic                  buf_rd_cs;
  logic                  buf_rd_en;
  logic [ADDR_WIDTH-1:0] buf_rd_addr;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic                  m_ready;

  modport master (
    input  start, base_addr, num_words, buf_empty, buf_rd_data, m_ready,
    output busy, done, buf_rd_cs, buf_rd_en, buf_rd_addr, m_valid, m_data, m_last
  );

  modport slave (
    output start, base_addr, num_words, buf_empty, buf_rd_data, m_ready,
    input  busy, done, buf_rd_cs, buf_rd_en, buf_rd_addr, m_valid, m_data, m_last
  );
endinterface

// File: rtl/imc_obuf_skid.sv
// Small FIFO holding words returned by the buffer until the consumer accepts them.
module imc_obuf_skid
  import imc_obuf_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = OBUF_SKID_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push_i,
  input  logic [DATA_WIDTH-1:0]          push_dat_i,
  input  logic                           pop_i,
  output logic [DATA_WIDTH-1:0]          head_dat_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  pop_ok;

  assign pop_ok = pop_i && (cnt_q != '0);
  assign cnt_d  = cnt_q + CW'(push_i) - CW'(pop_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_d;
    end
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign empty_o    = (cnt_q == '0);
  assign full_o     = (cnt_q == CW'(DEPTH));
  assign count_o    = cnt_q;

endmodule

// File: rtl/imc_obuf_reader.sv
// Fetches num_words entries from the output buffer (wrapping at RAM_DEPTH) and streams them out
// with last-word marking, absorbing the buffer's registered read latency and consumer backpressure.
module imc_obuf_reader
  import imc_obuf_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int RAM_DEPTH  = 64
) (
  input  logic               clk,
  input  logic               rst,
  imc_obuf_reader_if.master  bus
);
  localparam int CW  = ADDR_WIDTH + 1;
  localparam int OCW = $clog2(OBUF_SKID_DEPTH + 1);

  obuf_state_e                 state_q;
  logic [CW-1:0]               num_q, issued_q, acc_q;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic [OBUF_RD_LATENCY-1:0]  inflight_q;
  logic                        busy_q, done_q;

  logic                        skid_empty, skid_full, land;
  logic [OCW-1:0]              skid_cnt;
  logic [DATA_WIDTH-1:0]       skid_head;
  logic                        issue, pop, last_word;
  logic [2:0]                  pending;

  assign pop       = !skid_empty && bus.m_ready;
  assign last_word = (acc_q == num_q - CW'(1));
  assign land      = inflight_q[OBUF_RD_LATENCY-1];
  assign addr_d    = (addr_q == ADDR_WIDTH'(RAM_DEPTH-1)) ? '0 : addr_q + ADDR_WIDTH'(1);

  // A word leaving the skid this cycle frees its slot, so full-rate streaming keeps issuing.
  assign pending = 3'(skid_cnt) + 3'($countones(inflight_q));
  assign issue   = (state_q == ST_RUN) && !bus.buf_empty && (issued_q < num_q) &&
                   (pending < 3'(OBUF_SKID_DEPTH) + 3'(pop));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      num_q      <= '0;
      issued_q   <= '0;
      acc_q      <= '0;
      addr_q     <= '0;
      inflight_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      inflight_q <= (inflight_q << 1) | OBUF_RD_LATENCY'(issue);
      if (pop) acc_q <= acc_q + CW'(1);
      if (issue) begin
        issued_q <= issued_q + CW'(1);
        addr_q   <= addr_d;
      end
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            num_q    <= bus.num_words;
            addr_q   <= bus.base_addr;
            issued_q <= '0;
            acc_q    <= '0;
            if (bus.num_words == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (issue && (issued_q + CW'(1) == num_q)) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (pop && last_word) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  imc_obuf_skid #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (OBUF_SKID_DEPTH)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push_i     (land && !skid_full),
    .push_dat_i (bus.buf_rd_data),
    .pop_i      (pop),
    .head_dat_o (skid_head),
    .full_o     (skid_full),
    .empty_o    (skid_empty),
    .count_o    (skid_cnt)
  );

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.buf_rd_cs   = issue;
  assign bus.buf_rd_en   = issue;
  assign bus.buf_rd_addr = addr_q;
  assign bus.m_valid     = !skid_empty;
  assign bus.m_data      = skid_head;
  assign bus.m_last      = !skid_empty && last_word;

endmodule

// File: tb/tb_imc_obuf_reader.sv
// Randomized scoreboard bench for imc_obuf_reader against a word-list model of the buffer.
module tb_imc_obuf_reader;
  localparam int DW    = 32;
  localparam int AW    = 7;
  localparam int CW    = AW + 1;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imc_obuf_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  imc_obuf_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] mem [DEPTH];
  logic [DW:0]   exp_q [$];
  logic [AW-1:0] addr_q [$];

  int checks = 0, errors = 0;
  int cyc = 0;
  int rd_total = 0, acc_total = 0, v_total = 0, done_cnt = 0;
  int start_cyc = 0, first_rd_cyc = -1, first_v_cyc = -1, last_acc_cyc = -1, done_cyc = -1;
  int d0 = 0, r0 = 0, v0 = 0;
  bit hold_vld = 0;
  logic [DW-1:0] hold_dat;
  int rdy_mode = 0, emp_mode = 0, ph = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Buffer model: registered read, garbage on cycles without a read.
  always @(posedge clk) begin
    if (bus.buf_rd_cs && bus.buf_rd_en) bus.buf_rd_data <= mem[bus.buf_rd_addr[5:0]];
    else                                bus.buf_rd_data <= $urandom;
  end

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    bus.m_ready   = 1'b1;
    bus.buf_empty = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ph++;
      case (rdy_mode)
        0:       bus.m_ready = 1'b1;
        1:       bus.m_ready = ((ph % 3) == 0);
        default: bus.m_ready = 1'($urandom_range(0, 1));
      endcase
      if (emp_mode != 0) bus.buf_empty = ($urandom_range(0, 3) == 0);
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      chk(bus.buf_rd_cs == bus.buf_rd_en, "cs_eq_en", bus.buf_rd_cs, bus.buf_rd_en);
      if (bus.buf_rd_en) begin
        rd_total++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        chk(!bus.buf_empty, "rd_while_empty", bus.buf_empty, 0);
        if (addr_q.size() == 0) chk(1'b0, "unexpected_rd", bus.buf_rd_addr, 0);
        else begin
          logic [AW-1:0] ea;
          ea = addr_q.pop_front();
          chk(bus.buf_rd_addr == ea, "rd_addr", bus.buf_rd_addr, ea);
        end
      end
      if (bus.m_valid) begin
        v_total++;
        if (first_v_cyc < 0) first_v_cyc = cyc;
        if (hold_vld) chk(bus.m_data == hold_dat, "stall_hold", bus.m_data, hold_dat);
        if (bus.m_ready) begin
          acc_total++;
          last_acc_cyc = cyc;
          hold_vld = 0;
          if (exp_q.size() == 0) chk(1'b0, "unexpected_word", bus.m_data, 0);
          else begin
            logic [DW:0] e;
            e = exp_q.pop_front();
            chk(bus.m_data == e[DW-1:0], "m_data", bus.m_data, e[DW-1:0]);
            chk(bus.m_last == e[DW], "m_last", bus.m_last, e[DW]);
          end
        end else begin
          hold_vld = 1;
          hold_dat = bus.m_data;
        end
      end else begin
        if (hold_vld) chk(1'b0, "stall_drop", 0, 1);
        hold_vld = 0;
      end
      chk(rd_total - acc_total <= 2, "outstanding", rd_total - acc_total, 2);
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        chk(exp_q.size() == 0, "done_early", exp_q.size(), 0);
      end
    end
  end

  task automatic fill_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
  endtask

  task automatic launch(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      int a;
      a = (base + i) % DEPTH;
      exp_q.push_back({(i == n - 1), mem[a]});
      addr_q.push_back(AW'(a));
    end
    first_rd_cyc = -1; first_v_cyc = -1; last_acc_cyc = -1; done_cyc = -1;
    d0 = done_cnt; r0 = rd_total; v0 = v_total;
    bus.base_addr = AW'(base);
    bus.num_words = CW'(n);
    bus.start     = 1'b1;
    start_cyc     = cyc;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic finish_xfer(input string tag);
    int t;
    t = 0;
    while (done_cnt == d0 && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk(done_cnt > d0, {tag, "_done_seen"}, done_cnt - d0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk(done_cnt == d0 + 1, {tag, "_done_single"}, done_cnt - d0, 1);
    chk(exp_q.size() == 0, {tag, "_all_words"}, exp_q.size(), 0);
    chk(addr_q.size() == 0, {tag, "_all_reads"}, addr_q.size(), 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk(bus.busy == 0, {tag, "_busy"}, bus.busy, 0);
    chk(bus.done == 0, {tag, "_done"}, bus.done, 0);
    chk(bus.buf_rd_cs == 0, {tag, "_rd_cs"}, bus.buf_rd_cs, 0);
    chk(bus.buf_rd_en == 0, {tag, "_rd_en"}, bus.buf_rd_en, 0);
    chk(bus.buf_rd_addr == 0, {tag, "_rd_addr"}, bus.buf_rd_addr, 0);
    chk(bus.m_valid == 0, {tag, "_m_valid"}, bus.m_valid, 0);
    chk(bus.m_data == 0, {tag, "_m_data"}, bus.m_data, 0);
    chk(bus.m_last == 0, {tag, "_m_last"}, bus.m_last, 0);
  endtask

  initial begin
    int t, rs;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.num_words = '0;
    fill_mem();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1: basic latency and throughput
    launch(5, 4);
    finish_xfer("t1");
    chk(first_rd_cyc == start_cyc + 1, "t1_first_rd", first_rd_cyc - start_cyc, 1);
    chk(first_v_cyc == start_cyc + 3, "t1_first_valid", first_v_cyc - start_cyc, 3);
    chk(last_acc_cyc == start_cyc + 6, "t1_last_accept", last_acc_cyc - start_cyc, 6);
    chk(done_cyc == last_acc_cyc + 1, "t1_done_cycle", done_cyc - last_acc_cyc, 1);

    // 2: address wrap
    fill_mem();
    launch(62, 4);
    finish_xfer("t2");

    // 3: backpressure pattern 1,0,0
    fill_mem();
    rdy_mode = 1;
    launch(17, 6);
    finish_xfer("t3");
    rdy_mode = 0;

    // 4: buffer empty for 5 cycles after two issues
    fill_mem();
    launch(30, 8);
    t = 0;
    while (rd_total - r0 < 2 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    bus.buf_empty = 1'b1;
    rs = rd_total;
    repeat (5) @(posedge clk);
    #1;
    chk(rd_total == rs, "t4_stall_no_rd", rd_total - rs, 0);
    bus.buf_empty = 1'b0;
    finish_xfer("t4");
    chk(rd_total - r0 == 8, "t4_reads", rd_total - r0, 8);

    // 5: zero-length transfer
    launch(9, 0);
    finish_xfer("t5");
    chk(rd_total == r0, "t5_no_rd", rd_total - r0, 0);
    chk(v_total == v0, "t5_no_valid", v_total - v0, 0);
    chk(done_cyc - start_cyc >= 1 && done_cyc - start_cyc <= 2, "t5_done_lat", done_cyc - start_cyc, 2);

    // 6: reset while the third word is in flight
    fill_mem();
    launch(10, 8);
    t = 0;
    while (rd_total - r0 < 3 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk(rd_total - r0 == 3, "t6_reach_third", rd_total - r0, 3);
    rst = 1'b1;
    exp_q.delete();
    addr_q.delete();
    @(posedge clk);
    #1;
    hold_vld = 0;
    acc_total = rd_total;
    @(negedge clk);
    chk_outputs_zero("t6_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    d0 = done_cnt;
    repeat (5) @(posedge clk);
    #1;
    chk(done_cnt == d0, "t6_no_done", done_cnt - d0, 0);
    launch(40, 5);
    finish_xfer("t6_restart");

    // Random transfers with random backpressure and empty stalls
    rdy_mode = 2;
    emp_mode = 1;
    for (int k = 0; k < 8; k++) begin
      fill_mem();
      launch($urandom_range(0, DEPTH - 1), (k == 7) ? 70 : $urandom_range(1, 24));
      finish_xfer("rand");
    end
    emp_mode = 0;
    rdy_mode = 0;
    @(posedge clk);
    #1 bus.buf_empty = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
